// File: rtl/picomips_pkg.sv
// Shared types and instruction-field layout for the picoMIPS sequencer.
// Instruction word: op | rd | rs | imm, most-significant field first.
package picomips_pkg;

  localparam int PW     = 6;
  localparam int N      = 8;
  localparam int IW     = 3 + 3 + 3 + N;
  localparam int OP_MSB = IW - 1;
  localparam int RD_MSB = IW - 4;
  localparam int RS_MSB = IW - 7;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_ADDI  = 3'b010,
    OP_MULI  = 3'b011,
    OP_WAITH = 3'b100,
    OP_WAITL = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MULW   = 3'd3,
    WAIT   = 3'd4,
    HALTED = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/picomips_decode.sv
// Combinational decode: maps (state, ir, mul_done, in_flag) to datapath strobes,
// the next sequencer state and the program-counter update selection.
module picomips_decode
  import picomips_pkg::*;
(
  input  state_t         state,
  input  logic [IW-1:0]  ir,
  input  logic           mul_done,
  input  logic           in_flag,
  output state_t         next_state,
  output pc_sel_t        pc_sel,
  output logic           ir_load,
  output logic [2:0]     raddr1,
  output logic [2:0]     raddr2,
  output logic [N-1:0]   imm,
  output logic           reg_write,
  output logic           imm_sel,
  output logic           wsel,
  output logic           mul_start,
  output logic           halted
);

  opcode_t op;
  logic    wr_ok;

  assign op     = opcode_t'(ir[OP_MSB -: 3]);
  assign raddr1 = ir[RD_MSB -: 3];
  assign raddr2 = ir[RS_MSB -: 3];
  assign imm    = ir[N-1:0];
  // R0 is hard-wired to zero, so writes to it are dropped.
  assign wr_ok  = (raddr1 != 3'd0);

  // Next-state, pc-select and strobe decode.
  always_comb begin
    next_state = state;
    pc_sel     = PC_HOLD;
    ir_load    = 1'b0;
    reg_write  = 1'b0;
    imm_sel    = 1'b0;
    wsel       = 1'b0;
    mul_start  = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        ir_load    = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        case (op)
          OP_NOP: begin
            pc_sel     = PC_INC;
            next_state = FETCH;
          end
          OP_ADD, OP_ADDI: begin
            reg_write  = wr_ok;
            imm_sel    = (op == OP_ADDI);
            pc_sel     = PC_INC;
            next_state = FETCH;
          end
          OP_MULI: begin
            mul_start  = 1'b1;
            imm_sel    = 1'b1;
            next_state = MULW;
          end
          OP_WAITH, OP_WAITL: next_state = WAIT;
          OP_JMP: begin
            pc_sel     = PC_JUMP;
            next_state = FETCH;
          end
          OP_HALT: next_state = HALTED;
          default: next_state = FETCH;
        endcase
      end
      MULW: begin
        wsel    = 1'b1;
        imm_sel = 1'b1;
        if (mul_done) begin
          reg_write  = wr_ok;
          pc_sel     = PC_INC;
          next_state = FETCH;
        end else begin
          next_state = MULW;
        end
      end
      WAIT: begin
        // WAITH needs in_flag high, WAITL needs it low.
        if (in_flag == (op == OP_WAITH)) begin
          pc_sel     = PC_INC;
          next_state = FETCH;
        end else begin
          next_state = WAIT;
        end
      end
      HALTED: begin
        halted     = 1'b1;
        next_state = HALTED;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: rtl/picomips_seq.sv
// picoMIPS multi-cycle sequencer: holds pc, instruction register and state;
// all datapath controls are decoded combinationally from state and ir.
module picomips_seq
  import picomips_pkg::*;
#(
  parameter int Pw = PW,
  parameter int n  = N,
  parameter int Iw = IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [Iw-1:0] instr,
  input  logic          mul_done,
  input  logic          in_flag,
  output logic [Pw-1:0] pc,
  output logic [2:0]    Raddr1,
  output logic [2:0]    Raddr2,
  output logic          reg_write,
  output logic [n-1:0]  imm,
  output logic          imm_sel,
  output logic          wsel,
  output logic          mul_start,
  output logic          halted
);

  state_t        state;
  state_t        next_state;
  pc_sel_t       pc_sel;
  logic          ir_load;
  logic [Iw-1:0] ir;

  picomips_decode u_decode (
    .state      (state),
    .ir         (ir),
    .mul_done   (mul_done),
    .in_flag    (in_flag),
    .next_state (next_state),
    .pc_sel     (pc_sel),
    .ir_load    (ir_load),
    .raddr1     (Raddr1),
    .raddr2     (Raddr2),
    .imm        (imm),
    .reg_write  (reg_write),
    .imm_sel    (imm_sel),
    .wsel       (wsel),
    .mul_start  (mul_start),
    .halted     (halted)
  );

  // State, instruction and program-counter registers; pc+1 wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ir    <= {Iw{1'b0}};
      pc    <= {Pw{1'b0}};
    end else begin
      state <= next_state;
      if (ir_load) begin
        ir <= instr;
      end else begin
        ir <= ir;
      end
      case (pc_sel)
        PC_INC:  pc <= pc + {{(Pw-1){1'b0}}, 1'b1};
        PC_JUMP: pc <= ir[Pw-1:0];
        default: pc <= pc;
      endcase
    end
  end

endmodule
